freq_div3_monitor: RTL and testbench
====================================

Name: freq_div3_monitor

Overview:
- Consumer stage directly downstream of the divide-by-3 counter.
- Samples the divider's 2-bit phase count and the shared `start` enable, and checks the 0→1→2→0 sequence every cycle.
- Emits a one-cycle `tick` per completed F/3 period, counts periods, and reports lock and sticky error status to control/debug logic.
- Lets the system use the divider output as a qualified clock enable instead of a raw phase signal.

Parameters:
- LOCK_CYCLES, default 4: consecutive good periods (2→0 wraps) required to enter LOCKED; legal range 1..15.
- CNT_W, default 16: width of the `period_cnt` output.

Ports:
- clk, input, 1: system clock, same clock as the divider.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: same enable that drives the divider.
- div_count, input, 2: divider phase count.
- err_clr, input, 1: clears the sticky error and leaves FAULT.
- tick, output, 1: one-cycle pulse per good F/3 period.
- period_cnt, output, CNT_W: number of ticks since reset or clear.
- locked, output, 1: high in LOCKED state only.
- err, output, 1: sticky sequence-error flag.
- fsm_state, output, 2: IDLE=0, ACQ=1, LOCK=2, FAULT=3.

Behaviour:

Reset (rst=1 at a clk edge):
- start_q=0, cnt_q=0, good_cnt=0, chk_en=0, state=IDLE.
- tick=0, period_cnt=0, locked=0, err=0.
- rst overrides every other input.

Sampling, every edge:
- start_q<=start, cnt_q<=div_count.
- chk_en<=1 on the first edge after rst deasserts.
- The check at an edge is suppressed when chk_en=0 (the divider has no reset).

Expected-value rule:
- If start_q=1, exp = (cnt_q==2) ? 0 : cnt_q+1. The value 3 is never legal; cnt_q=3 gives exp=0 but div_count is still flagged as illegal.
- If start_q=0, exp = 0.
- mismatch = chk_en && (div_count != exp || div_count==3).
- good_wrap = chk_en && start_q && cnt_q==2 && div_count==0.

FSM (registered, evaluated at each edge):
- IDLE:
  - mismatch → FAULT.
  - Else start_q=1 → ACQ with good_cnt=0.
- ACQ:
  - mismatch → FAULT.
  - start_q=0 → IDLE, good_cnt=0.
  - On good_wrap, good_cnt++. When good_cnt reaches LOCK_CYCLES → LOCK.
- LOCK:
  - mismatch → FAULT.
  - start_q=0 → IDLE.
  - Otherwise stay.
- FAULT:
  - Stay until err_clr=1 with no mismatch that edge.
  - Exit goes to IDLE if start_q=0, else to ACQ; good_cnt=0.
- Mismatch has priority over err_clr and over the start_q=0 exit.

Outputs:
- err: set the edge the FSM enters FAULT; held until the FAULT exit edge.
- locked: 1 exactly while state=LOCK.
- tick: registered; high for one cycle after any good_wrap edge where state ∈ {ACQ, LOCK} and no mismatch. Latency is one clk after div_count returns to 0. Never high in IDLE or FAULT.
- period_cnt:
  - Increments with each tick and wraps 2^CNT_W−1 → 0 silently.
  - Holds in IDLE and FAULT.
  - Cleared on rst and on the FAULT exit edge.

Boundary cases:
- start toggling high for one cycle: the divider shows 1 then 0. Exp is 1 then 0, so no error, no tick, and the FSM goes IDLE→ACQ→IDLE.
- start falling while div_count=2 or 1: the divider zeroes, which is legal (exp=0), so no error and no tick.
- The steady-state tick period is exactly 3 clocks.

Test Plan:
1. Reset with start=0 for 2 cycles, then start=1 held for 30 cycles.
   - First tick 4 clks after start rises (counts 1, 2, 0, then the tick register).
   - Ticks every 3 clks.
   - locked=1 one edge after the 4th good wrap; period_cnt=10 after 10 ticks.
2. Locked, then force div_count=1 when 0 is expected.
   - err=1 and fsm_state=3 the next cycle; locked=0; tick stops; period_cnt holds.
   - err_clr=1 with a good sequence → ACQ, err=0, period_cnt=0.
3. Locked, force div_count=3 for one cycle → FAULT.
   - Assert err_clr in the same cycle as a second mismatch: FSM stays in FAULT, err stays 1.
4. start pulse of one cycle, and start dropped at div_count=2.
   - No err, no tick, FSM returns to IDLE, good_cnt reset.
5. CNT_W=4, run 17 ticks → period_cnt wraps 15→0→1; no err.
6. Assert rst mid-LOCK while div_count=1.
   - All outputs 0 the next cycle.
   - The check is suppressed on the first post-reset edge, and re-acquisition completes normally.

Source files
------------

// File: rtl/freq_div3_monitor.sv
`default_nettype none
// ============================================================================
// Module   : freq_div3_monitor
// Function : Sits directly after the divide-by-3 counter. Checks the
//            0->1->2->0 phase sequence every cycle. Emits a qualified
//            one-cycle tick for each F/3 period and counts those periods.
//            Reports lock status and a sticky sequence-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module freq_div3_monitor #(
  parameter int unsigned LOCK_CYCLES = 4,   // good wraps needed to lock (1..15)
  parameter int unsigned CNT_W       = 16   // width of period_cnt
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       div_count,
  input  logic             err_clr,
  output logic             tick,
  output logic [CNT_W-1:0] period_cnt,
  output logic             locked,
  output logic             err,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [3:0] c_LOCK_TARGET = 4'(LOCK_CYCLES);

  state_t           state_q, state_d;
  logic             start_q;
  logic [1:0]       cnt_q;
  logic             chk_en_q;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             err_q, err_d;

  logic [1:0]       exp_cnt;
  logic             mismatch;
  logic             good_wrap;

  // Predict this edge's divider value from last edge's sample.
  // The divider has no reset, so nothing is judged until chk_en_q is set.
  always_comb begin
    exp_cnt = 2'd0;
    if (start_q) begin
      exp_cnt = (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
    end
    mismatch  = chk_en_q && ((div_count != exp_cnt) || (div_count == 2'd3));
    good_wrap = chk_en_q && start_q && (cnt_q == 2'd2) && (div_count == 2'd0);
  end

  // Next-state logic. A mismatch always wins over err_clr and over a start drop.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    tick_d       = 1'b0;
    period_cnt_d = period_cnt_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mismatch) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
        end else if (start_q) begin
          state_d    = ST_ACQ;
          good_cnt_d = 4'd0;
        end
      end
      ST_ACQ: begin
        if (mismatch) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
        end else if (!start_q) begin
          state_d    = ST_IDLE;
          good_cnt_d = 4'd0;
        end else if (good_wrap) begin
          tick_d       = 1'b1;
          period_cnt_d = period_cnt_q + CNT_W'(1);
          good_cnt_d   = good_cnt_q + 4'd1;
          if ((good_cnt_q + 4'd1) == c_LOCK_TARGET) begin
            state_d = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        if (mismatch) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
        end else if (!start_q) begin
          state_d = ST_IDLE;
        end else if (good_wrap) begin
          tick_d       = 1'b1;
          period_cnt_d = period_cnt_q + CNT_W'(1);
        end
      end
      ST_FAULT: begin
        // Leaving FAULT restarts acquisition from scratch and clears the count.
        if (err_clr && !mismatch) begin
          state_d      = start_q ? ST_ACQ : ST_IDLE;
          good_cnt_d   = 4'd0;
          period_cnt_d = '0;
          err_d        = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and sample registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      cnt_q        <= 2'd0;
      chk_en_q     <= 1'b0;
      good_cnt_q   <= 4'd0;
      tick_q       <= 1'b0;
      period_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      cnt_q        <= div_count;
      chk_en_q     <= 1'b1;
      good_cnt_q   <= good_cnt_d;
      tick_q       <= tick_d;
      period_cnt_q <= period_cnt_d;
      err_q        <= err_d;
    end
  end

  assign tick       = tick_q;
  assign period_cnt = period_cnt_q;
  assign locked     = (state_q == ST_LOCK);
  assign err        = err_q;
  assign fsm_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_div3_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_div3_monitor
// Function : Directed self-checking bench for freq_div3_monitor. A behavioural
//            divide-by-3 counter feeds the monitor. A force path injects
//            illegal phase values. A second instance with CNT_W=4 exercises
//            wrap-around of the period counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_div3_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        err_clr = 1'b0;
  logic        force_en = 1'b0;
  logic [1:0]  force_val = 2'd0;
  logic [1:0]  div_cnt = 2'd0;
  logic [1:0]  div_in;

  logic        tick, locked, err;
  logic [15:0] period_cnt;
  logic [1:0]  fsm_state;
  logic        tick4, locked4, err4;
  logic [3:0]  period_cnt4;
  logic [1:0]  fsm_state4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Behavioural divider: no reset, zeroes whenever start is low.
  always @(posedge clk) begin
    div_cnt <= start ? ((div_cnt == 2'd2) ? 2'd0 : div_cnt + 2'd1) : 2'd0;
  end

  assign div_in = force_en ? force_val : div_cnt;

  freq_div3_monitor #(.LOCK_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .div_count(div_in), .err_clr(err_clr),
    .tick(tick), .period_cnt(period_cnt), .locked(locked), .err(err),
    .fsm_state(fsm_state)
  );

  freq_div3_monitor #(.LOCK_CYCLES(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .div_count(div_in), .err_clr(err_clr),
    .tick(tick4), .period_cnt(period_cnt4), .locked(locked4), .err(err4),
    .fsm_state(fsm_state4)
  );

  // Compare one observed value with its expected value and count the outcome.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nt;
    // ---------------- reset ----------------
    cyc(); cyc();
    check("rst_tick",   tick, 0);
    check("rst_period", period_cnt, 0);
    check("rst_locked", locked, 0);
    check("rst_err",    err, 0);
    check("rst_state",  fsm_state, 0);
    rst = 1'b0;
    cyc(); cyc();
    check("idle_state", fsm_state, 0);
    check("idle_err",   err, 0);

    // ---------------- 1: acquire and lock ----------------
    start = 1'b1;
    nt = 0;
    for (int i = 1; i <= 31; i++) begin
      int et;
      cyc();
      et = (i >= 4 && ((i - 4) % 3) == 0) ? 1 : 0;
      nt += et;
      check("t1_tick",   tick, et);
      check("t1_period", period_cnt, nt);
      check("t1_state",  fsm_state, (i >= 13) ? 2 : ((i >= 2) ? 1 : 0));
      check("t1_err",    err, 0);
    end
    check("t1_locked", locked, 1);
    check("t1_period10", period_cnt, 10);

    // ---------------- 2: wrong phase while locked ----------------
    cyc(); cyc();
    force_en = 1'b1; force_val = 2'd1;
    cyc();
    check("t2_err",    err, 1);
    check("t2_state",  fsm_state, 3);
    check("t2_locked", locked, 0);
    check("t2_tick",   tick, 0);
    check("t2_period", period_cnt, 10);
    force_en = 1'b0;
    cyc(); cyc();
    check("t2_hold_state",  fsm_state, 3);
    check("t2_hold_err",    err, 1);
    check("t2_hold_tick",   tick, 0);
    check("t2_hold_period", period_cnt, 10);
    err_clr = 1'b1;
    cyc();
    check("t2_clr_state",  fsm_state, 1);
    check("t2_clr_err",    err, 0);
    check("t2_clr_period", period_cnt, 0);
    check("t2_clr_tick",   tick, 0);
    err_clr = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      check("t2_reacq_tick",   tick, ((i % 3) == 0) ? 1 : 0);
      check("t2_reacq_period", period_cnt, i / 3);
      check("t2_reacq_locked", locked, (i == 12) ? 1 : 0);
    end

    // ---------------- 3: illegal value 3, then clear during a mismatch ----
    force_en = 1'b1; force_val = 2'd3;
    cyc();
    check("t3_state",  fsm_state, 3);
    check("t3_err",    err, 1);
    check("t3_locked", locked, 0);
    check("t3_period", period_cnt, 4);
    force_en = 1'b0; err_clr = 1'b1;
    cyc();
    check("t3_clr_blocked_state", fsm_state, 3);
    check("t3_clr_blocked_err",   err, 1);
    cyc();
    check("t3_clr_state",  fsm_state, 1);
    check("t3_clr_err",    err, 0);
    check("t3_clr_period", period_cnt, 0);
    err_clr = 1'b0;

    // ---------------- 4: start drop, one-cycle pulse, drop at phase 2 ----
    start = 1'b0;
    cyc();
    check("t4_drop_state0", fsm_state, 1);
    cyc();
    check("t4_drop_state1", fsm_state, 0);
    check("t4_drop_err",    err, 0);
    start = 1'b1;
    cyc();
    check("t4_pulse_s1", fsm_state, 0);
    start = 1'b0;
    cyc();
    check("t4_pulse_s2", fsm_state, 1);
    cyc();
    check("t4_pulse_s3",  fsm_state, 0);
    check("t4_pulse_err", err, 0);
    cyc();
    check("t4_pulse_tick",   tick, 0);
    check("t4_pulse_period", period_cnt, 0);
    start = 1'b1;
    cyc();
    check("t4_p2_s1", fsm_state, 0);
    cyc();
    check("t4_p2_s2", fsm_state, 1);
    start = 1'b0;
    cyc();
    check("t4_p2_s3",   fsm_state, 1);
    check("t4_p2_err3", err, 0);
    cyc();
    check("t4_p2_s4",   fsm_state, 0);
    check("t4_p2_tick", tick, 0);
    check("t4_p2_err4", err, 0);
    cyc();
    check("t4_p2_tick5",  tick, 0);
    check("t4_p2_period", period_cnt, 0);

    // ---------------- 6 (+5): reset mid-lock, reacquire, 4-bit wrap ----
    start = 1'b1;
    for (int i = 1; i <= 13; i++) cyc();
    check("t6_pre_locked", locked, 1);
    rst = 1'b1;
    cyc();
    check("t6_rst_tick",    tick, 0);
    check("t6_rst_period",  period_cnt, 0);
    check("t6_rst_locked",  locked, 0);
    check("t6_rst_err",     err, 0);
    check("t6_rst_state",   fsm_state, 0);
    check("t6_rst_period4", period_cnt4, 0);
    check("t6_rst_locked4", locked4, 0);
    check("t6_rst_err4",    err4, 0);
    check("t6_rst_state4",  fsm_state4, 0);
    rst = 1'b0;
    cyc();
    check("t6_suppr_err",   err, 0);
    check("t6_suppr_state", fsm_state, 0);
    cyc();
    check("t6_acq_state", fsm_state, 1);
    check("t6_acq_err",   err, 0);
    check("t6_acq_tick",  tick, 0);
    for (int i = 1; i <= 51; i++) begin
      cyc();
      check("t6_tick",    tick, ((i % 3) == 0) ? 1 : 0);
      check("t6_tick4",   tick4, ((i % 3) == 0) ? 1 : 0);
      check("t6_period",  period_cnt, i / 3);
      check("t6_period4", period_cnt4, (i / 3) % 16);
      check("t6_locked",  locked, (i >= 12) ? 1 : 0);
      check("t6_err4",    err4, 0);
    end
    check("t5_period17",  period_cnt, 17);
    check("t5_wrap4",     period_cnt4, 1);
    check("t5_locked4",   locked4, 1);
    check("t5_state4",    fsm_state4, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
